// File: rtl/imm_decode_pipe_if.sv
// imm_decode_pipe_if: ready/valid bus carrying an instruction in and a decoded immediate out
interface imm_decode_pipe_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     inst;
    logic [2:0]      in_sel;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_sel;
    logic            out_illegal;
    modport master (
        output in_valid, inst, in_sel, out_ready,
        input  in_ready, out_valid, out_imm, out_sel, out_illegal
    );
    modport slave (
        input  in_valid, inst, in_sel, out_ready,
        output in_ready, out_valid, out_imm, out_sel, out_illegal
    );
endinterface

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: RISC-V immediate extraction behind a single ready/valid register stage
module imm_decode_pipe #(
    parameter int XLEN     = 32,
    parameter bit AUTO_SEL = 1'b0
) (
    input logic clk,
    input logic rst,
    imm_decode_pipe_if.slave bus
);
    logic [31:0]     i;
    logic [2:0]      auto_code;
    logic [2:0]      sel;
    logic [XLEN-1:0] imm;
    assign i = bus.inst;
    // Opcode-driven type selection; the 0011011 word-immediate opcode only exists on RV64
    always_comb begin
        case (i[6:0])
            7'b0010011, 7'b0000011, 7'b1100111: auto_code = 3'd0;
            7'b0011011: auto_code = (XLEN == 64) ? 3'd0 : 3'd7;
            7'b0100011: auto_code = 3'd1;
            7'b1100011: auto_code = 3'd2;
            7'b1101111: auto_code = 3'd3;
            7'b0110111, 7'b0010111: auto_code = 3'd4;
            7'b1110011: auto_code = i[14] ? 3'd5 : 3'd0;
            default: auto_code = 3'd7;
        endcase
    end
    assign sel = AUTO_SEL ? auto_code : bus.in_sel;
    // Immediate assembly; reserved codes fall through to zero
    always_comb begin
        case (sel)
            3'd0: imm = XLEN'($signed(i[31:20]));
            3'd1: imm = XLEN'($signed({i[31:25], i[11:7]}));
            3'd2: imm = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd3: imm = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'd4: imm = XLEN'($signed({i[31:12], 12'b0}));
            3'd5: imm = XLEN'(i[19:15]);
            default: imm = '0;
        endcase
    end
    assign bus.in_ready = !bus.out_valid || bus.out_ready;
    // Output register: load on accept, drop valid on a transfer with nothing new behind it
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_valid   <= 1'b0;
            bus.out_imm     <= '0;
            bus.out_sel     <= 3'd0;
            bus.out_illegal <= 1'b0;
        end else begin
            if (bus.in_ready) bus.out_valid <= bus.in_valid;
            if (bus.in_valid && bus.in_ready) begin
                bus.out_imm     <= imm;
                bus.out_sel     <= sel;
                bus.out_illegal <= sel[2] & sel[1];
            end
        end
    end
endmodule

// File: tb/tb_imm_decode_pipe.sv
// tb_imm_decode_pipe: directed vector table plus handshake corner sequences on three configurations
module tb_imm_decode_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;
    imm_decode_pipe_if #(.XLEN(32)) b0 ();
    imm_decode_pipe_if #(.XLEN(32)) b1 ();
    imm_decode_pipe_if #(.XLEN(64)) b2 ();
    imm_decode_pipe #(.XLEN(32), .AUTO_SEL(1'b0)) u0 (.clk(clk), .rst(rst), .bus(b0.slave));
    imm_decode_pipe #(.XLEN(32), .AUTO_SEL(1'b1)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
    imm_decode_pipe #(.XLEN(64), .AUTO_SEL(1'b1)) u2 (.clk(clk), .rst(rst), .bus(b2.slave));
    always #5 clk = ~clk;
    typedef struct {
        logic [31:0] inst;
        logic [2:0]  sel;
        logic [31:0] e0;
        logic [2:0]  s0;
        logic [31:0] e1;
        logic [2:0]  s1;
        logic [63:0] e2;
        logic [2:0]  s2;
    } vec_t;
    vec_t tbl [15];
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic put(input logic v, input logic [31:0] w, input logic [2:0] s, input logic r);
        b0.in_valid = v; b0.inst = w; b0.in_sel = s; b0.out_ready = r;
        b1.in_valid = v; b1.inst = w; b1.in_sel = s; b1.out_ready = r;
        b2.in_valid = v; b2.inst = w; b2.in_sel = s; b2.out_ready = r;
    endtask
    task automatic tick();
        @(posedge clk);
        #2;
    endtask
    task automatic chk_row(input int n, input vec_t t);
        string p;
        p = $sformatf("row%0d", n);
        chk({p, " u0 valid"}, 64'(b0.out_valid), 64'd1);
        chk({p, " u0 imm"}, 64'(b0.out_imm), 64'(t.e0));
        chk({p, " u0 sel"}, 64'(b0.out_sel), 64'(t.s0));
        chk({p, " u0 illegal"}, 64'(b0.out_illegal), 64'(t.s0 >= 3'd6));
        chk({p, " u1 valid"}, 64'(b1.out_valid), 64'd1);
        chk({p, " u1 imm"}, 64'(b1.out_imm), 64'(t.e1));
        chk({p, " u1 sel"}, 64'(b1.out_sel), 64'(t.s1));
        chk({p, " u1 illegal"}, 64'(b1.out_illegal), 64'(t.s1 >= 3'd6));
        chk({p, " u2 imm"}, b2.out_imm, t.e2);
        chk({p, " u2 sel"}, 64'(b2.out_sel), 64'(t.s2));
        chk({p, " u2 illegal"}, 64'(b2.out_illegal), 64'(t.s2 >= 3'd6));
        chk({p, " in_ready"}, 64'(b0.in_ready), 64'd1);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
    initial begin
        tbl[0]  = '{32'hFFF00093, 3'd0, 32'hFFFFFFFF, 3'd0, 32'hFFFFFFFF, 3'd0, 64'hFFFFFFFFFFFFFFFF, 3'd0};
        tbl[1]  = '{32'hFE20AE23, 3'd1, 32'hFFFFFFFC, 3'd1, 32'hFFFFFFFC, 3'd1, 64'hFFFFFFFFFFFFFFFC, 3'd1};
        tbl[2]  = '{32'h0000006F, 3'd3, 32'h0, 3'd3, 32'h0, 3'd3, 64'h0, 3'd3};
        tbl[3]  = '{32'h000FD073, 3'd5, 32'h1F, 3'd5, 32'h1F, 3'd5, 64'h1F, 3'd5};
        tbl[4]  = '{32'h800000B7, 3'd4, 32'h80000000, 3'd4, 32'h80000000, 3'd4, 64'hFFFFFFFF80000000, 3'd4};
        tbl[5]  = '{32'h0000007F, 3'd6, 32'h0, 3'd6, 32'h0, 3'd7, 64'h0, 3'd7};
        tbl[6]  = '{32'h80000063, 3'd2, 32'hFFFFF000, 3'd2, 32'hFFFFF000, 3'd2, 64'hFFFFFFFFFFFFF000, 3'd2};
        tbl[7]  = '{32'h000000E3, 3'd2, 32'h800, 3'd2, 32'h800, 3'd2, 64'h800, 3'd2};
        tbl[8]  = '{32'h001000EF, 3'd3, 32'h800, 3'd3, 32'h800, 3'd3, 64'h800, 3'd3};
        tbl[9]  = '{32'h8000006F, 3'd3, 32'hFFF00000, 3'd3, 32'hFFF00000, 3'd3, 64'hFFFFFFFFFFF00000, 3'd3};
        tbl[10] = '{32'h12301073, 3'd0, 32'h123, 3'd0, 32'h123, 3'd0, 64'h123, 3'd0};
        tbl[11] = '{32'hFFF0009B, 3'd0, 32'hFFFFFFFF, 3'd0, 32'h0, 3'd7, 64'hFFFFFFFFFFFFFFFF, 3'd0};
        tbl[12] = '{32'h7FF00003, 3'd0, 32'h7FF, 3'd0, 32'h7FF, 3'd0, 64'h7FF, 3'd0};
        tbl[13] = '{32'h12345017, 3'd4, 32'h12345000, 3'd4, 32'h12345000, 3'd4, 64'h12345000, 3'd4};
        tbl[14] = '{32'h00000013, 3'd7, 32'h0, 3'd7, 32'h0, 3'd0, 64'h0, 3'd0};
        rst = 1'b1;
        put(1'b1, 32'hFFF00093, 3'd0, 1'b1);
        tick();
        tick();
        chk("reset valid", 64'(b0.out_valid), 64'd0);
        chk("reset imm", 64'(b0.out_imm), 64'd0);
        chk("reset sel", 64'(b0.out_sel), 64'd0);
        chk("reset illegal", 64'(b0.out_illegal), 64'd0);
        chk("reset u2 imm", b2.out_imm, 64'd0);
        chk("reset in_ready", 64'(b0.in_ready), 64'd1);
        rst = 1'b0;
        put(1'b0, 32'h0, 3'd0, 1'b1);
        tick();
        chk("no accept under reset", 64'(b0.out_valid), 64'd0);
        for (int n = 0; n < 15; n++) begin
            put(1'b1, tbl[n].inst, tbl[n].sel, 1'b1);
            tick();
            chk_row(n, tbl[n]);
        end
        put(1'b0, 32'h0, 3'd0, 1'b1);
        tick();
        chk("drain valid", 64'(b0.out_valid), 64'd0);
        chk("drain hold imm", 64'(b0.out_imm), 64'h0);
        put(1'b1, 32'h00100093, 3'd0, 1'b0);
        tick();
        chk("stall first valid", 64'(b0.out_valid), 64'd1);
        chk("stall first imm", 64'(b0.out_imm), 64'd1);
        chk("stall in_ready", 64'(b0.in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            put(1'b1, 32'h00200093 + (32'(k) << 20), 3'(k + 1), 1'b0);
            tick();
            chk("stall valid", 64'(b0.out_valid), 64'd1);
            chk("stall imm", 64'(b0.out_imm), 64'd1);
            chk("stall sel", 64'(b0.out_sel), 64'd0);
            chk("stall in_ready", 64'(b0.in_ready), 64'd0);
            chk("stall u2 imm", b2.out_imm, 64'd1);
        end
        put(1'b1, 32'h00500093, 3'd0, 1'b1);
        #1;
        chk("release in_ready", 64'(b0.in_ready), 64'd1);
        tick();
        chk("b2b first valid", 64'(b0.out_valid), 64'd1);
        chk("b2b first imm", 64'(b0.out_imm), 64'd5);
        put(1'b1, 32'h00600093, 3'd0, 1'b1);
        tick();
        chk("b2b second valid", 64'(b0.out_valid), 64'd1);
        chk("b2b second imm", 64'(b0.out_imm), 64'd6);
        put(1'b0, 32'h00700093, 3'd0, 1'b1);
        tick();
        chk("transfer no accept valid", 64'(b0.out_valid), 64'd0);
        chk("idle hold imm", 64'(b0.out_imm), 64'd6);
        put(1'b1, 32'hFFF00093, 3'd0, 1'b0);
        tick();
        chk("pre-reset stall imm", 64'(b0.out_imm), 64'hFFFFFFFF);
        put(1'b1, 32'h00100093, 3'd0, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid-stall reset valid", 64'(b0.out_valid), 64'd0);
        chk("mid-stall reset imm", 64'(b0.out_imm), 64'd0);
        chk("mid-stall reset u2 imm", b2.out_imm, 64'd0);
        chk("mid-stall reset in_ready", 64'(b0.in_ready), 64'd1);
        rst = 1'b0;
        put(1'b0, 32'h0, 3'd0, 1'b0);
        tick();
        chk("post-reset idle valid", 64'(b0.out_valid), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imm_decode_pipe.md
IMM_DECODE_PIPE -- requirements
Module: imm_decode_pipe

Interface
REQ-001 Parameter XLEN, default 32, datapath width of the immediate; legal values are 32 and 64.
REQ-002 Parameter AUTO_SEL, default 0. When 0, the immediate type comes from the in_sel port. When 1, it is decoded from inst[6:0] and in_sel is ignored.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  inst/in_sel are presented this cycle.
REQ-006 in_ready  output  1  stage can accept an input this cycle.
REQ-007 inst  input  32  RV32/RV64 base instruction word.
REQ-008 in_sel  input  3  immediate type code: I=0, S=1, B=2, J=3, U=4, Z=5; codes 6 and 7 are reserved.
REQ-009 out_valid  output  1  out_imm/out_sel/out_illegal hold a result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_imm  output  XLEN  sign- or zero-extended immediate.
REQ-012 out_sel  output  3  type code actually used for the held result.
REQ-013 out_illegal  output  1  no immediate type could be resolved for the held result.

Function
REQ-014 Extraction for I, S, B, J and U, per the RISC-V base format, sign-extended from inst[31] to XLEN bits:
- I = inst[31:20].
- S = {inst[31:25], inst[11:7]}.
- B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}.
- J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}.
- U = {inst[31:12], 12'b0}. For XLEN=64, bits 63:32 replicate inst[31].
REQ-015 Z type is the CSR immediate, inst[19:15], zero-extended to XLEN.
REQ-016 Reserved codes (6, 7) give out_imm=0 and out_illegal=1.
REQ-017 AUTO_SEL=1 decode from inst[6:0]:
- I: 0010011, 0000011, 1100111, 0011011.
- S: 0100011.
- B: 1100011.
- J: 1101111.
- U: 0110111, 0010111.
- Z: 1110011 with inst[14]=1.
- 1110011 with inst[14]=0: I.
- Any other opcode: out_sel=7, out_imm=0, out_illegal=1.
- Opcode 0011011 is legal only when XLEN=64; with XLEN=32 it is treated as an unknown opcode.
REQ-018 Handshake and latency:
- One register stage; latency is exactly 1 cycle from input accept to out_valid.
- Input accept = in_valid & in_ready.
- Output transfer = out_valid & out_ready.
REQ-019 in_ready = !out_valid | out_ready (combinational). There is no combinational path from inst or in_sel to any output.
REQ-020 Accept and transfer in the same cycle: the register loads the new result and out_valid stays 1, with no bubble.
REQ-021 Transfer without accept: out_valid falls to 0 on the next edge.
REQ-022 Stall (out_valid=1, out_ready=0): out_imm, out_sel and out_illegal hold stable and in_ready=0. in_valid with changing inst data is ignored.
REQ-023 in_valid=0: the register does not load, so outputs hold their last value, but out_valid follows REQ-021.
REQ-024 Throughput is one result per cycle while out_ready=1.

Reset
REQ-025 While rst=1 at a clock edge:
- out_valid=0, out_imm=0, out_sel=0, out_illegal=0.
- in_ready evaluates to 1 in the cycle after reset.
REQ-026 Reset mid-stall discards the held result, and no transfer is reported for it.
REQ-027 An input presented in the same cycle as rst=1 is not accepted.

Verification
REQ-028 XLEN=32, AUTO_SEL=0, in_sel=I, inst=0xFFF00093 -> next cycle out_valid=1, out_imm=0xFFFFFFFF.
REQ-029 XLEN=32, AUTO_SEL=1:
- inst=0xFE20AE23 -> out_sel=1, out_imm=0xFFFFFFFC.
- inst=0x0000006F -> out_sel=3, out_imm=0.
- inst=0x000FD073 -> out_sel=5, out_imm=0x0000001F.
REQ-030 XLEN=64, AUTO_SEL=1, inst=0x800000B7 -> out_sel=4, out_imm=0xFFFFFFFF80000000.
REQ-031 Hold out_ready=0 for 3 cycles with in_valid=1 and changing inst -> in_ready=0 and outputs unchanged. Release out_ready -> back-to-back results with no loss and no duplication.
REQ-032 AUTO_SEL=1, inst=0x0000007F -> out_illegal=1, out_sel=7, out_imm=0. Also check AUTO_SEL=0 with in_sel=6 -> out_illegal=1, out_imm=0.
REQ-033 Assert rst during a stall -> next cycle out_valid=0, out_imm=0, in_ready=1.
